// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit instruction
// word and streams it, with its target word address, to an instruction-memory
// writer over a valid/ready handshake. Field sets whose immediate does not fit
// the selected format, whose branch/jump target is misaligned, or whose opcode
// is not supported are consumed without producing an output word, and the
// first such cause is recorded in a sticky error register.
module inst_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst,
    output logic [31:0] addr,
    output logic        err,
    output logic [1:0]  err_code,
    input  logic        err_clr,
    output logic [15:0] count
);

    // Opcodes handled by the encoder
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Error causes, in increasing priority
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_ALIGN = 2'b10;
    localparam logic [1:0] ERR_OPC   = 2'b11;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_SH,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    // True when v[31:msb] are all copies of the same bit, i.e. v is
    // representable as a signed (msb+1)-bit quantity.
    function automatic logic fits_signed(input logic [31:0] v, input logic [4:0] msb);
        logic signed [31:0] hi;
        hi = $signed(v) >>> msb;
        return (hi == 32'sd0) || (hi == -32'sd1);
    endfunction

    // Field packing for each format; the immediate bit scattering is the
    // exact inverse of the decode-stage immediate generator.
    function automatic logic [31:0] pack(
        input fmt_e        f,
        input logic [6:0]  op,
        input logic [4:0]  rd_f,
        input logic [4:0]  rs1_f,
        input logic [4:0]  rs2_f,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] im
    );
        logic [31:0] w;
        w = '0;
        case (f)
            FMT_R:   w = {f7, rs2_f, rs1_f, f3, rd_f, op};
            FMT_I:   w = {im[11:0], rs1_f, f3, rd_f, op};
            FMT_SH:  w = {f7, im[4:0], rs1_f, f3, rd_f, op};
            FMT_S:   w = {im[11:5], rs2_f, rs1_f, f3, im[4:0], op};
            FMT_B:   w = {im[12], im[10:5], rs2_f, rs1_f, f3, im[4:1], im[11], op};
            FMT_U:   w = {im[31:12], rd_f, op};
            FMT_J:   w = {im[20], im[10:1], im[11], im[19:12], rd_f, op};
            default: w = '0;
        endcase
        return w;
    endfunction

    // Error classification with precedence unsupported > misaligned > range.
    function automatic logic [1:0] classify(input fmt_e f, input logic [31:0] im);
        logic [1:0] c;
        c = ERR_NONE;
        case (f)
            FMT_R:   c = ERR_NONE;
            FMT_I,
            FMT_S:   c = fits_signed(im, 5'd11) ? ERR_NONE : ERR_RANGE;
            FMT_SH:  c = (im[31:5] == 27'd0) ? ERR_NONE : ERR_RANGE;
            FMT_B:   c = im[0] ? ERR_ALIGN :
                         (fits_signed(im, 5'd12) ? ERR_NONE : ERR_RANGE);
            FMT_J:   c = im[0] ? ERR_ALIGN :
                         (fits_signed(im, 5'd20) ? ERR_NONE : ERR_RANGE);
            FMT_U:   c = (im[11:0] == 12'd0) ? ERR_NONE : ERR_RANGE;
            default: c = ERR_OPC;
        endcase
        return c;
    endfunction

    fmt_e        fmt;
    logic [31:0] enc_word;
    logic [1:0]  enc_err;
    logic        accept;
    logic        xfer;
    logic        good_accept;
    logic        bad_accept;

    logic        out_valid_q, out_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] count_q, count_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;

    // Select the encoding format from the opcode (and funct3 for shifts)
    always_comb begin
        fmt = FMT_BAD;
        case (opcode)
            OP_R:             fmt = FMT_R;
            OP_IMM:           fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SH : FMT_I;
            OP_LOAD, OP_JALR: fmt = FMT_I;
            OP_STORE:         fmt = FMT_S;
            OP_BRANCH:        fmt = FMT_B;
            OP_LUI, OP_AUIPC: fmt = FMT_U;
            OP_JAL:           fmt = FMT_J;
            default:          fmt = FMT_BAD;
        endcase
    end

    // Build the candidate word and its error cause from the current field set
    always_comb begin
        enc_word = pack(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
        enc_err  = classify(fmt, imm);
    end

    // Handshake qualifiers: the output slot frees up when it is empty or drains
    always_comb begin
        in_ready    = !out_valid_q || out_ready;
        accept      = in_valid && in_ready;
        xfer        = out_valid_q && out_ready;
        good_accept = accept && (enc_err == ERR_NONE);
        bad_accept  = accept && (enc_err != ERR_NONE);
    end

    // Next state of the output slot, address/count and sticky error
    always_comb begin
        out_valid_d = out_valid_q;
        inst_d      = inst_q;
        addr_d      = addr_q;
        count_d     = count_q;
        err_d       = err_q;
        err_code_d  = err_code_q;

        // A drained word advances the write pointer and the emitted count.
        if (xfer) begin
            out_valid_d = 1'b0;
            addr_d      = addr_q + 32'd4;
            count_d     = count_q + 16'd1;
        end

        // A clean field set refills the slot; a faulty one leaves it alone.
        if (good_accept) begin
            out_valid_d = 1'b1;
            inst_d      = enc_word;
        end

        // Only the first error is recorded, but a clear in the same cycle
        // as a new error lets the new cause through.
        if (bad_accept && (!err_q || err_clr)) begin
            err_d      = 1'b1;
            err_code_d = enc_err;
        end else if (err_clr) begin
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
        end
    end

    // Output slot register; the held word stays stable under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            inst_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            inst_q      <= inst_d;
        end
    end

    // Write address of the word in the slot and the emitted-word counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= BASE_ADDR;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    // Sticky error flag and first-cause code
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign out_valid = out_valid_q;
    assign inst      = inst_q;
    assign addr      = addr_q;
    assign count     = count_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Builds 32-bit RV32I instruction words from decoded fields (opcode, registers, funct, full 32-bit immediate), packing the immediate into the I/S/B/U/J bit layout. It is the inverse of the immediate generator in the decode stage. It feeds the boot/test instruction-memory write port: each encoded word is emitted with its target word address through a valid/ready handshake. Range, alignment and opcode errors are flagged; the faulty instruction is not emitted.

Parameters:
BASE_ADDR, 32'h0000_0000, address of the first emitted instruction; must be word-aligned.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  field set valid
in_ready  output  1  encoder can accept a field set
opcode  input  7  instruction opcode
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
funct3  input  3  funct3 field
funct7  input  7  funct7 field; also the upper bits for shift-immediates
imm  input  32  full signed immediate (byte offset for B/J; upper-aligned value for U)
out_valid  output  1  inst/addr valid
out_ready  input  1  memory writer accepts
inst  output  32  encoded instruction
addr  output  32  word address of inst
err  output  1  sticky error flag
err_code  output  2  first error cause: 00 none, 01 range, 10 misaligned, 11 unsupported opcode
err_clr  input  1  clears err and err_code
count  output  16  number of instructions emitted (wraps)

Behaviour:
- Reset (async, any time): out_valid=0, inst=0, addr=BASE_ADDR, err=0, err_code=00, count=0. Any in-flight word is discarded.
- Single output register stage. Latency is 1 cycle from the accept (in_valid and in_ready) to out_valid.
- in_ready = !out_valid || out_ready, so accept and drain can happen in the same cycle. No combinational path from in_* to out_*.
- While out_valid=1 and out_ready=0, inst and addr are held stable.
- A transfer happens when out_valid and out_ready are both high. On each transfer, addr += 4 (wraps at 2^32) and count += 1 (wraps at 2^16).
- Formats by opcode:
  - R (0110011): funct7|rs2|rs1|funct3|rd|op; imm ignored.
  - I (0010011, 0000011, 1100111): imm[11:0]|rs1|funct3|rd|op.
  - Shift-immediate (0010011 with funct3 001 or 101): funct7|imm[4:0]|rs1|funct3|rd|op; requires imm[31:5]=0.
  - S (0100011): imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
  - B (1100011): imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
  - U (0110111 LUI, 0010111 AUIPC): imm[31:12]|rd|op.
  - J (1101111): imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Checks, per format:
  - I and S: imm[31:11] all equal, else range error.
  - Shift-immediate: see the imm[31:5]=0 rule above.
  - B: imm[31:12] all equal, else range; imm[0]=0, else misaligned.
  - J: imm[31:20] all equal, else range; imm[0]=0, else misaligned.
  - U: imm[11:0]=0, else range.
  - Any other opcode: unsupported.
- Error precedence: unsupported > misaligned > range.
- Erroneous field sets are still accepted (the handshake completes) but produce no output word. addr and count are unchanged.
- err is set on the first error. err_code latches the cause of that first error only, until cleared.
- If err_clr coincides with a new error, the new error wins (err=1, new code).
- Errors do not block later valid field sets.

Test Plan:
- addi x1,x0,-1 (op 0010011, rd=1, f3=0, rs1=0, imm=32'hFFFFFFFF) -> inst=32'hFFF00093, addr=BASE_ADDR, out_valid one cycle after accept, count=1.
- sw x2,8(x1) (op 0100011, f3=010, rs1=1, rs2=2, imm=8), then beq x0,x0,-4 (op 1100011, imm=32'hFFFFFFFC), sent back-to-back with out_ready=1 -> 32'h0020A423 @BASE, then 32'hFE000EE3 @BASE+4, one per cycle.
- lui x5 (op 0110111, rd=5, imm=32'h12345000) -> 32'h123452B7; jal x0,0 (op 1101111) -> 32'h0000006F.
- Error sequence:
  - addi with imm=2048 -> err=1, err_code=01, no out_valid, addr and count unchanged.
  - Then jal with imm=3 -> err_code stays 01.
  - err_clr, then jal imm=3 -> err_code=10.
  - opcode 1111111 -> err_code=11 after a clear.
- Backpressure: hold out_ready=0, present two field sets -> first accepted, in_ready=0 afterwards, inst held stable. Release out_ready -> both drain in order, addr advances by 4 per transfer.
- Reset asserted while out_valid=1 and out_ready=0 -> out_valid=0 immediately (async), addr=BASE_ADDR, count=0, err=0.
